// File: rtl/proc_pkg.sv
// Shared definitions for the decode/operand-fetch stage: instruction field
// positions, opcode constants, shift encodings and the ID/EX register layout.
package proc_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RADDR_W   = 4;
  localparam int unsigned NREGS     = 15;  // R0..R14 stored; R15 is the PC
  localparam int unsigned PC_OFFSET = 8;

  localparam logic [RADDR_W-1:0] REG_PC = 4'd15;

  // Instruction field positions
  localparam int unsigned COND_MSB   = 31;
  localparam int unsigned COND_LSB   = 28;
  localparam int unsigned I_BIT      = 25;
  localparam int unsigned OP_MSB     = 24;
  localparam int unsigned OP_LSB     = 21;
  localparam int unsigned S_BIT      = 20;
  localparam int unsigned RN_MSB     = 19;
  localparam int unsigned RN_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 12;
  localparam int unsigned SHAMT_MSB  = 11;
  localparam int unsigned SHAMT_LSB  = 7;
  localparam int unsigned SHTYPE_MSB = 6;
  localparam int unsigned SHTYPE_LSB = 5;
  localparam int unsigned RM_MSB     = 3;
  localparam int unsigned RM_LSB     = 0;

  // Opcode constants
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_MOV = 4'b1101;

  typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_RSV} shift_t;

  typedef struct packed {
    logic            valid;
    logic [3:0]      cond;
    logic [3:0]      op;
    logic            fun;
    logic            set_flags;
    logic [4:0]      shift_amount;
    shift_t          shift_type;
    logic [3:0]      rd_addr;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
  } id_ex_t;

  // imm8 rotated right by twice the 4-bit rotate field; doubling the word
  // turns the rotate into a plain right shift.
  function automatic logic [XLEN-1:0] expand_imm(input logic [11:0] imm12);
    logic [4:0]        rot;
    logic [2*XLEN-1:0] dbl;
    rot = {imm12[11:8], 1'b0};
    dbl = {24'h0, imm12[7:0], 24'h0, imm12[7:0]};
    dbl = dbl >> rot;
    return dbl[XLEN-1:0];
  endfunction

endpackage

// File: rtl/reg_file.sv
// 15x32 register file with two combinational read ports, one synchronous
// write port, write-to-read bypass and R15 reads returning pc + PC_OFFSET.
module reg_file
  import proc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RADDR_W-1:0] raddr1,
  input  logic [RADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]    rdata1,
  output logic [XLEN-1:0]    rdata2,
  input  logic               wen,
  input  logic [RADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]    wdata,
  input  logic [XLEN-1:0]    pc
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] pc_rd;
  logic            wr_ok;

  assign pc_rd = pc + XLEN'(PC_OFFSET);
  assign wr_ok = wen && (waddr != REG_PC);

  // Read ports: R15 injection first, then same-cycle write bypass, then storage
  always_comb begin
    if (raddr1 == REG_PC) begin
      rdata1 = pc_rd;
    end else if (wr_ok && (waddr == raddr1)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = mem_q[raddr1];
    end
    if (raddr2 == REG_PC) begin
      rdata2 = pc_rd;
    end else if (wr_ok && (waddr == raddr2)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = mem_q[raddr2];
    end
  end

  // Storage: synchronous clear on reset, writes to R15 dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: slices the instruction into shifter/ALU
// controls, fetches operands, builds the rotated immediate and registers the
// result into the ID/EX pipeline register (reset > flush > stall > load).
module operand_fetch_stage
  import proc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [31:0]        instr,
  input  logic [XLEN-1:0]    pc,
  input  logic               stall,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]    wb_data,
  output logic               out_valid,
  output logic [3:0]         out_cond,
  output logic [3:0]         out_op,
  output logic               out_fun,
  output logic               out_set_flags,
  output logic [4:0]         out_shift_amount,
  output logic [1:0]         out_shift_type,
  output logic [3:0]         out_rd_addr,
  output logic [XLEN-1:0]    out_rd1,
  output logic [XLEN-1:0]    out_rd2
);

  logic [XLEN-1:0] rn_data;
  logic [XLEN-1:0] rm_data;
  logic [XLEN-1:0] ext_imm;
  id_ex_t          id_ex_d;
  id_ex_t          id_ex_q;

  // Class bits and the register-shift flag (instr[4]) are not used by this stage
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[27:26], instr[4]};

  reg_file u_reg_file (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (instr[RN_MSB:RN_LSB]),
    .raddr2 (instr[RM_MSB:RM_LSB]),
    .rdata1 (rn_data),
    .rdata2 (rm_data),
    .wen    (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .pc     (pc)
  );

  assign ext_imm = expand_imm(instr[11:0]);

  // Next ID/EX entry: fields always decoded, valid follows in_valid
  always_comb begin
    id_ex_d              = '0;
    id_ex_d.valid        = in_valid;
    id_ex_d.cond         = instr[COND_MSB:COND_LSB];
    id_ex_d.op           = instr[OP_MSB:OP_LSB];
    id_ex_d.fun          = instr[I_BIT];
    id_ex_d.set_flags    = instr[S_BIT];
    id_ex_d.shift_amount = instr[SHAMT_MSB:SHAMT_LSB];
    id_ex_d.shift_type   = shift_t'(instr[SHTYPE_MSB:SHTYPE_LSB]);
    id_ex_d.rd_addr      = instr[RD_MSB:RD_LSB];
    id_ex_d.rd1          = rn_data;
    id_ex_d.rd2          = instr[I_BIT] ? ext_imm : rm_data;
  end

  // ID/EX register: flush inserts an all-zero bubble, stall holds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex_q <= '0;
    end else if (flush) begin
      id_ex_q <= '0;
    end else if (!stall) begin
      id_ex_q <= id_ex_d;
    end
  end

  assign out_valid        = id_ex_q.valid;
  assign out_cond         = id_ex_q.cond;
  assign out_op           = id_ex_q.op;
  assign out_fun          = id_ex_q.fun;
  assign out_set_flags    = id_ex_q.set_flags;
  assign out_shift_amount = id_ex_q.shift_amount;
  assign out_shift_type   = id_ex_q.shift_type;
  assign out_rd_addr      = id_ex_q.rd_addr;
  assign out_rd1          = id_ex_q.rd1;
  assign out_rd2          = id_ex_q.rd2;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed vector table,
// hand-written stall/flush/reset sequences and randomized traffic, all
// compared against a behavioural model of the stage.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, stall, flush, wb_en;
  logic [31:0] instr, pc, wb_data;
  logic [3:0]  wb_addr;
  logic        out_valid, out_fun, out_set_flags;
  logic [3:0]  out_cond, out_op, out_rd_addr;
  logic [4:0]  out_shift_amount;
  logic [1:0]  out_shift_type;
  logic [31:0] out_rd1, out_rd2;

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .instr            (instr),
    .pc               (pc),
    .stall            (stall),
    .flush            (flush),
    .wb_en            (wb_en),
    .wb_addr          (wb_addr),
    .wb_data          (wb_data),
    .out_valid        (out_valid),
    .out_cond         (out_cond),
    .out_op           (out_op),
    .out_fun          (out_fun),
    .out_set_flags    (out_set_flags),
    .out_shift_amount (out_shift_amount),
    .out_shift_type   (out_shift_type),
    .out_rd_addr      (out_rd_addr),
    .out_rd1          (out_rd1),
    .out_rd2          (out_rd2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        valid;
    logic [3:0]  cond, op;
    logic        fun, sflags;
    logic [4:0]  shamt;
    logic [1:0]  shtype;
    logic [3:0]  rd;
    logic [31:0] rd1, rd2;
  } exp_t;

  exp_t        m;
  logic [31:0] m_regs [16];

  function automatic exp_t zero_exp();
    exp_t z;
    z.valid = 0; z.cond = 0; z.op = 0; z.fun = 0; z.sflags = 0;
    z.shamt = 0; z.shtype = 0; z.rd = 0; z.rd1 = 0; z.rd2 = 0;
    return z;
  endfunction

  // Architectural read as seen by an instruction during this cycle
  function automatic logic [31:0] m_read(input int a);
    if (a == 15) return pc + 32'd8;
    if (wb_en && (int'(wb_addr) == a)) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    int          r;
    logic [31:0] v;
    v = ins & 32'hFF;
    r = 2 * int'((ins >> 8) & 32'hF);
    if (r == 0) return v;
    return (v >> r) | (v << (32 - r));
  endfunction

  task automatic model_edge();
    exp_t n;
    if (!rst_n) begin
      m = zero_exp();
      for (int i = 0; i < 15; i++) m_regs[i] = 32'h0;
      return;
    end
    n.valid  = in_valid;
    n.cond   = instr[31:28];
    n.op     = instr[24:21];
    n.fun    = instr[25];
    n.sflags = instr[20];
    n.shamt  = instr[11:7];
    n.shtype = instr[6:5];
    n.rd     = instr[15:12];
    n.rd1    = m_read(int'(instr[19:16]));
    n.rd2    = instr[25] ? m_imm(instr) : m_read(int'(instr[3:0]));
    if (flush) m = zero_exp();
    else if (!stall) m = n;
    if (wb_en && wb_addr != 4'd15) m_regs[wb_addr] = wb_data;
  endtask

  task automatic check_all();
    chk("valid", 32'(out_valid), 32'(m.valid));
    chk("cond", 32'(out_cond), 32'(m.cond));
    chk("op", 32'(out_op), 32'(m.op));
    chk("fun", 32'(out_fun), 32'(m.fun));
    chk("set_flags", 32'(out_set_flags), 32'(m.sflags));
    chk("shift_amount", 32'(out_shift_amount), 32'(m.shamt));
    chk("shift_type", 32'(out_shift_type), 32'(m.shtype));
    chk("rd_addr", 32'(out_rd_addr), 32'(m.rd));
    chk("rd1", out_rd1, m.rd1);
    chk("rd2", out_rd2, m.rd2);
  endtask

  // One clock: model consumes the pre-edge inputs, outputs sampled 1 after edge
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] instr, pc;
    logic        iv, wen;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        st, fl;
    logic        ev;
    logic [31:0] e_rd1, e_rd2;
    logic        efun;
    logic [4:0]  eshamt;
    logic [1:0]  eshtype;
  } vec_t;

  vec_t tbl [10];

  initial begin
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    m = zero_exp();
    rst_n = 0; in_valid = 0; stall = 0; flush = 0; wb_en = 0;
    instr = 0; pc = 0; wb_data = 0; wb_addr = 0;

    // Instruction under test in row 1 is MOV R0, R3, LSR #2
    tbl[0] = '{32'h0000_0000, 32'h0, 1'b0, 1'b1, 4'd3,  32'hDEAD_BEEF, 1'b0, 1'b0,
               1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 2'd0};
    tbl[1] = '{32'hE1A0_0123, 32'h100, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0,
               1'b1, 32'h0, 32'hDEAD_BEEF, 1'b0, 5'd2, 2'b01};
    tbl[2] = '{32'hE095_1003, 32'h104, 1'b1, 1'b1, 4'd5, 32'h1234, 1'b0, 1'b0,
               1'b1, 32'h1234, 32'hDEAD_BEEF, 1'b0, 5'd0, 2'd0};
    tbl[3] = '{32'hE08F_1003, 32'h200, 1'b1, 1'b1, 4'd15, 32'hFFFF, 1'b0, 1'b0,
               1'b1, 32'h208, 32'hDEAD_BEEF, 1'b0, 5'd0, 2'd0};
    tbl[4] = '{32'hE085_100F, 32'h300, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0,
               1'b1, 32'h1234, 32'h308, 1'b0, 5'd0, 2'd0};
    tbl[5] = '{32'hE3AF_04FF, 32'hFFFF_FFFC, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0,
               1'b1, 32'h4, 32'hFF00_0000, 1'b1, 5'd9, 2'b11};
    tbl[6] = '{32'hE3A0_0012, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0,
               1'b1, 32'h0, 32'h12, 1'b1, 5'd0, 2'd0};
    tbl[7] = '{32'hE3A0_0F01, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0,
               1'b1, 32'h0, 32'h4, 1'b1, 5'd30, 2'd0};
    tbl[8] = '{32'hE087_1000, 32'h0, 1'b1, 1'b1, 4'd7, 32'h77, 1'b1, 1'b1,
               1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 2'd0};
    tbl[9] = '{32'hE087_1000, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0,
               1'b1, 32'h77, 32'h0, 1'b0, 5'd0, 2'd0};

    // Reset held for two cycles, then every stored register reads zero
    tick();
    tick();
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_rd1", out_rd1, 32'h0);
    rst_n = 1;
    in_valid = 1;
    for (int i = 0; i < 15; i++) begin
      logic [3:0] a;
      a = 4'(i);
      instr = {4'hE, 4'h0, 4'h8, a, 4'h1, 8'h00, a};
      tick();
      chk("reset_reg_rn", out_rd1, 32'h0);
      chk("reset_reg_rm", out_rd2, 32'h0);
    end

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      instr = tbl[i].instr; pc = tbl[i].pc; in_valid = tbl[i].iv;
      wb_en = tbl[i].wen; wb_addr = tbl[i].waddr; wb_data = tbl[i].wdata;
      stall = tbl[i].st; flush = tbl[i].fl;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_rd1", i), out_rd1, tbl[i].e_rd1);
      chk($sformatf("vec%0d_rd2", i), out_rd2, tbl[i].e_rd2);
      chk($sformatf("vec%0d_fun", i), 32'(out_fun), 32'(tbl[i].efun));
      chk($sformatf("vec%0d_shamt", i), 32'(out_shift_amount), 32'(tbl[i].eshamt));
      chk($sformatf("vec%0d_shtype", i), 32'(out_shift_type), 32'(tbl[i].eshtype));
    end
    wb_en = 0; stall = 0; flush = 0;

    // Stall: A loaded, then held for 3 cycles while B is presented
    instr = 32'hE085_1003; pc = 0; in_valid = 1;
    tick();
    chk("stall_A_rd1", out_rd1, 32'h1234);
    stall = 1; instr = 32'hE087_1000; in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_valid", 32'(out_valid), 32'h1);
      chk("stall_hold_rd1", out_rd1, 32'h1234);
      chk("stall_hold_rd2", out_rd2, 32'hDEAD_BEEF);
    end
    stall = 0; in_valid = 1;
    tick();
    chk("stall_release_rd1", out_rd1, 32'h77);
    chk("stall_release_valid", 32'(out_valid), 32'h1);

    // Reset during stall clears the register and the register file
    stall = 1; rst_n = 0;
    tick();
    chk("rst_stall_valid", 32'(out_valid), 32'h0);
    chk("rst_stall_rd1", out_rd1, 32'h0);
    rst_n = 1; stall = 0;
    tick();
    chk("after_rst_valid", 32'(out_valid), 32'h1);
    chk("after_rst_r7", out_rd1, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      in_valid = 1'($urandom);
      instr    = $urandom;
      pc       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      wb_en    = 1'($urandom);
      wb_addr  = 4'($urandom);
      wb_data  = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
